lanes_tx_scheduler: RTL and testbench

Transmit-side sequencer for the two-lane serializer. It starts and stops serialization, and arbitrates each word slot between the LTSSM ordered-set source and the transport data source, inserting idle words when neither has data. It owns the serializer's `enable_ser` and `gen_speed` inputs and drives both lanes' parallel words, so neither source needs to track the serializer's word period.

---
 rtl/usb4_tx_pkg.sv | 35 +++
 rtl/tx_slot_arbiter.sv | 49 ++++
 rtl/lanes_tx_scheduler.sv | 151 +++++++++++++++
 tb/tb_lanes_tx_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb4_tx_pkg.sv
// Shared definitions for the two-lane transmit path: speed codes, active word
// widths, slot source encodings and the scheduler state enumeration.
package usb4_tx_pkg;

   localparam logic [1:0] GEN4 = 2'b00;
   localparam logic [1:0] GEN3 = 2'b01;
   localparam logic [1:0] GEN2 = 2'b10;

   localparam int unsigned W_GEN4 = 8;
   localparam int unsigned W_GEN3 = 132;
   localparam int unsigned W_GEN2 = 66;

   typedef enum logic [1:0] {
      SRC_IDLE = 2'b00,
      SRC_OS   = 2'b01,
      SRC_DATA = 2'b10
   } slot_src_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_RUN   = 2'b10,
      ST_DRAIN = 2'b11
   } tx_state_e;

   // Code 11 is not a defined speed and falls back to the narrowest width.
   function automatic int unsigned active_width(input logic [1:0] gen);
      case (gen)
         GEN3:    return W_GEN3;
         GEN2:    return W_GEN2;
         default: return W_GEN4;
      endcase
   endfunction

endpackage

// File: rtl/tx_slot_arbiter.sv
// Per-slot priority arbiter between the ordered-set and data sources, with a
// burst counter that forces a data slot after a run of ordered-set grants.
module tx_slot_arbiter
   import usb4_tx_pkg::*;
#(
   parameter int unsigned OS_BURST_MAX = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      arb_en,
   input  logic      os_valid,
   input  logic      data_valid,
   output logic      grant_os,
   output logic      grant_data,
   output slot_src_e slot_src
);

   localparam int unsigned CNT_W = 3;

   logic [CNT_W-1:0] r_os_cnt;
   logic             w_force_data;

   assign w_force_data = data_valid && (r_os_cnt == CNT_W'(OS_BURST_MAX));

   always_comb begin
      slot_src = SRC_IDLE;
      if (w_force_data)    slot_src = SRC_DATA;
      else if (os_valid)   slot_src = SRC_OS;
      else if (data_valid) slot_src = SRC_DATA;
   end

   assign grant_os   = (slot_src == SRC_OS);
   assign grant_data = (slot_src == SRC_DATA);

   // Only ordered-set grants that starve pending data extend the burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_os_cnt <= '0;
      end else if (arb_en) begin
         if (grant_os) begin
            if (data_valid && (r_os_cnt != {CNT_W{1'b1}}))
               r_os_cnt <= r_os_cnt + CNT_W'(1);
         end else begin
            r_os_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/lanes_tx_scheduler.sv
// Transmit sequencer for the two-lane serializer: start/stop control, per-slot
// source arbitration, speed-dependent width masking and the lane word registers.
module lanes_tx_scheduler
   import usb4_tx_pkg::*;
#(
   parameter int unsigned WIDTH        = 132,
   parameter int unsigned OS_BURST_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_en,
   input  logic [1:0]       gen_speed_in,
   input  logic             ser_load,
   input  logic             os_valid,
   input  logic [WIDTH-1:0] os_word,
   output logic             os_ready,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] data_lane0,
   input  logic [WIDTH-1:0] data_lane1,
   output logic             data_ready,
   output logic             enable_ser,
   output logic [1:0]       gen_speed,
   output logic [WIDTH-1:0] lane_0_word,
   output logic [WIDTH-1:0] lane_1_word,
   output logic [1:0]       slot_src,
   output logic             busy
);

   tx_state_e        r_state;
   tx_state_e        w_next_state;
   logic             w_load;
   logic             w_grant_os;
   logic             w_grant_data;
   slot_src_e        w_slot_src;
   logic [1:0]       w_speed;
   int unsigned      w_act_width;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_word0;
   logic [WIDTH-1:0] w_word1;

   logic             r_enable_ser;
   logic             r_busy;
   logic [1:0]       r_gen_speed;
   logic [1:0]       r_slot_src;
   logic [WIDTH-1:0] r_lane_0_word;
   logic [WIDTH-1:0] r_lane_1_word;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // A DRAIN ser_load ends the burst even if tx_en comes back in that cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (tx_en) w_next_state = ST_START;
         ST_START: w_next_state = ST_RUN;
         ST_RUN:   if (!tx_en) w_next_state = ST_DRAIN;
         ST_DRAIN: begin
            if (ser_load)   w_next_state = ST_IDLE;
            else if (tx_en) w_next_state = ST_RUN;
         end
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load = 1'b0;
      case (r_state)
         ST_START: w_load = 1'b1;
         ST_RUN:   w_load = ser_load;
         default:  w_load = 1'b0;
      endcase
      if (rst) w_load = 1'b0;
   end

   assign os_ready   = w_load & w_grant_os;
   assign data_ready = w_load & w_grant_data;

   tx_slot_arbiter #(
      .OS_BURST_MAX (OS_BURST_MAX)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .arb_en     (w_load),
      .os_valid   (os_valid),
      .data_valid (data_valid),
      .grant_os   (w_grant_os),
      .grant_data (w_grant_data),
      .slot_src   (w_slot_src)
   );

   // START loads with the incoming speed since gen_speed is latched in that same edge.
   assign w_speed     = (r_state == ST_START) ? gen_speed_in : r_gen_speed;
   assign w_act_width = active_width(w_speed);

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         w_mask[i] = (i < w_act_width);
   end

   always_comb begin
      w_word0 = '0;
      w_word1 = '0;
      case (w_slot_src)
         SRC_OS: begin
            w_word0 = os_word;
            w_word1 = os_word;
         end
         SRC_DATA: begin
            w_word0 = data_lane0;
            w_word1 = data_lane1;
         end
         default: begin
            w_word0 = '0;
            w_word1 = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enable_ser  <= 1'b0;
         r_busy        <= 1'b0;
         r_gen_speed   <= 2'b00;
         r_slot_src    <= SRC_IDLE;
         r_lane_0_word <= '0;
         r_lane_1_word <= '0;
      end else begin
         r_enable_ser <= (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN);
         r_busy       <= (w_next_state != ST_IDLE);
         if (r_state == ST_START)
            r_gen_speed <= gen_speed_in;
         if (w_load) begin
            r_slot_src    <= w_slot_src;
            r_lane_0_word <= w_word0 & w_mask;
            r_lane_1_word <= w_word1 & w_mask;
         end
      end
   end

   assign enable_ser  = r_enable_ser;
   assign busy        = r_busy;
   assign gen_speed   = r_gen_speed;
   assign slot_src    = r_slot_src;
   assign lane_0_word = r_lane_0_word;
   assign lane_1_word = r_lane_1_word;

endmodule

// File: tb/tb_lanes_tx_scheduler.sv
// Directed self-checking bench for lanes_tx_scheduler.
module tb_lanes_tx_scheduler;

   localparam int unsigned WIDTH = 132;
   localparam int unsigned SPACE = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             tx_en;
   logic [1:0]       gen_speed_in;
   logic             ser_load;
   logic             os_valid;
   logic [WIDTH-1:0] os_word;
   logic             os_ready;
   logic             data_valid;
   logic [WIDTH-1:0] data_lane0;
   logic [WIDTH-1:0] data_lane1;
   logic             data_ready;
   logic             enable_ser;
   logic [1:0]       gen_speed;
   logic [WIDTH-1:0] lane_0_word;
   logic [WIDTH-1:0] lane_1_word;
   logic [1:0]       slot_src;
   logic             busy;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] pat_a5;
   logic [WIDTH-1:0] pat_os;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] ones;

   always #5 clk = ~clk;

   lanes_tx_scheduler #(
      .WIDTH        (WIDTH),
      .OS_BURST_MAX (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_en        (tx_en),
      .gen_speed_in (gen_speed_in),
      .ser_load     (ser_load),
      .os_valid     (os_valid),
      .os_word      (os_word),
      .os_ready     (os_ready),
      .data_valid   (data_valid),
      .data_lane0   (data_lane0),
      .data_lane1   (data_lane1),
      .data_ready   (data_ready),
      .enable_ser   (enable_ser),
      .gen_speed    (gen_speed),
      .lane_0_word  (lane_0_word),
      .lane_1_word  (lane_1_word),
      .slot_src     (slot_src),
      .busy         (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // One ser_load pulse; readies are sampled mid-cycle before the edge.
   task automatic load_pulse(output logic o_os_rdy, output logic o_data_rdy);
      ser_load = 1'b1;
      #1;
      o_os_rdy   = os_ready;
      o_data_rdy = data_ready;
      tick();
      ser_load = 1'b0;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      tx_en        = 1'b0;
      ser_load     = 1'b0;
      os_valid     = 1'b0;
      data_valid   = 1'b0;
      gen_speed_in = 2'b01;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({enable_ser, busy, os_ready, data_ready, slot_src, gen_speed} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 00000000", {enable_ser, busy, os_ready, data_ready, slot_src, gen_speed});
      end
      checks++;
      if ({lane_0_word, lane_1_word} !== '0) begin
         errors++;
         $display("FAIL reset_lanes got %h %h exp 0", lane_0_word, lane_1_word);
      end
   endtask

   task automatic test_gen3_startup();
      do_reset();
      gen_speed_in = 2'b01;
      os_valid     = 1'b1;
      os_word      = pat_a5;
      tx_en        = 1'b1;
      tick();
      checks++;
      if ({os_ready, data_ready, enable_ser} !== 3'b100) begin
         errors++;
         $display("FAIL start_ready got %b exp 100", {os_ready, data_ready, enable_ser});
      end
      tick();
      checks++;
      if ({enable_ser, busy, slot_src, gen_speed} !== 6'b11_01_01) begin
         errors++;
         $display("FAIL start_ctrl got %b exp 110101", {enable_ser, busy, slot_src, gen_speed});
      end
      checks++;
      if (lane_0_word !== pat_a5 || lane_1_word !== pat_a5) begin
         errors++;
         $display("FAIL start_lanes got %h %h exp %h", lane_0_word, lane_1_word, pat_a5);
      end
   endtask

   // START is grant 0; with both sources pending data takes grants 4, 9, ...
   task automatic test_fairness();
      logic o_r, d_r, exp_d;
      do_reset();
      gen_speed_in = 2'b01;
      os_valid     = 1'b1;
      os_word      = pat_os;
      data_valid   = 1'b1;
      data_lane0   = d0;
      data_lane1   = d1;
      tx_en        = 1'b1;
      tick();
      tick();
      for (int g = 1; g <= 10; g++) begin
         exp_d = ((g % 5) == 4);
         load_pulse(o_r, d_r);
         checks++;
         if ({o_r, d_r} !== {~exp_d, exp_d}) begin
            errors++;
            $display("FAIL fair_ready[%0d] got %b exp %b", g, {o_r, d_r}, {~exp_d, exp_d});
         end
         checks++;
         if (slot_src !== (exp_d ? 2'b10 : 2'b01) || lane_0_word !== (exp_d ? d0 : pat_os)) begin
            errors++;
            $display("FAIL fair_slot[%0d] got %b %h exp_data %b", g, slot_src, lane_0_word, exp_d);
         end
         gap(SPACE - 1);
      end
   endtask

   task automatic test_idle_fill();
      logic o_r, d_r;
      do_reset();
      tx_en = 1'b1;
      tick();
      checks++;
      if ({os_ready, data_ready} !== 2'b00) begin
         errors++;
         $display("FAIL idle_start_ready got %b exp 00", {os_ready, data_ready});
      end
      tick();
      for (int n = 0; n < 2; n++) begin
         load_pulse(o_r, d_r);
         checks++;
         if ({o_r, d_r, enable_ser, slot_src} !== 5'b00100 || lane_0_word !== '0 || lane_1_word !== '0) begin
            errors++;
            $display("FAIL idle_fill[%0d] got %b %h %h exp 00100 0 0", n, {o_r, d_r, enable_ser, slot_src}, lane_0_word, lane_1_word);
         end
         gap(3);
      end
      data_lane0 = d0;
      data_lane1 = d1;
      data_valid = 1'b1;
      gap(2);
      load_pulse(o_r, d_r);
      checks++;
      if ({o_r, d_r, slot_src} !== 4'b0110 || lane_0_word !== d0 || lane_1_word !== d1) begin
         errors++;
         $display("FAIL idle_resume got %b %h %h exp 0110 %h %h", {o_r, d_r, slot_src}, lane_0_word, lane_1_word, d0, d1);
      end
   endtask

   task automatic test_masking();
      logic o_r, d_r;
      logic [WIDTH-1:0] exp2;
      logic [WIDTH-1:0] exp4;
      exp2 = {{(WIDTH-66){1'b0}}, {66{1'b1}}};
      exp4 = {{(WIDTH-8){1'b0}}, 8'hFF};
      do_reset();
      gen_speed_in = 2'b10;
      data_valid   = 1'b1;
      data_lane0   = ones;
      data_lane1   = ones;
      tx_en        = 1'b1;
      tick();
      tick();
      checks++;
      if (lane_0_word !== exp2 || lane_1_word !== exp2) begin
         errors++;
         $display("FAIL mask_gen2 got %h %h exp %h", lane_0_word, lane_1_word, exp2);
      end
      gen_speed_in = 2'b01;
      load_pulse(o_r, d_r);
      checks++;
      if (lane_0_word !== exp2 || gen_speed !== 2'b10 || d_r !== 1'b1) begin
         errors++;
         $display("FAIL mask_speed_hold got %h %b %b exp %h 10 1", lane_0_word, gen_speed, d_r, exp2);
      end
      for (int s = 0; s < 2; s++) begin
         do_reset();
         gen_speed_in = (s == 0) ? 2'b00 : 2'b11;
         data_valid   = 1'b1;
         tx_en        = 1'b1;
         tick();
         tick();
         checks++;
         if (lane_0_word !== exp4 || lane_1_word !== exp4 || gen_speed !== ((s == 0) ? 2'b00 : 2'b11)) begin
            errors++;
            $display("FAIL mask_gen4[%0d] got %h %h %b exp %h", s, lane_0_word, lane_1_word, gen_speed, exp4);
         end
      end
   endtask

   task automatic test_drain();
      logic o_r, d_r;
      logic drain_bad;
      do_reset();
      gen_speed_in = 2'b01;
      data_valid   = 1'b1;
      data_lane0   = d0;
      data_lane1   = d1;
      tx_en        = 1'b1;
      tick();
      tick();
      load_pulse(o_r, d_r);
      gap(3);
      tx_en = 1'b0;
      drain_bad = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (data_ready !== 1'b0 || enable_ser !== 1'b1) drain_bad = 1'b1;
      end
      checks++;
      if (drain_bad !== 1'b0) begin
         errors++;
         $display("FAIL drain_hold got %b exp 0", drain_bad);
      end
      load_pulse(o_r, d_r);
      checks++;
      if ({o_r, d_r, enable_ser, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL drain_end got %b exp 0000", {o_r, d_r, enable_ser, busy});
      end
      // Re-assert tx_en mid-drain; the next slot must still be served.
      tx_en = 1'b1;
      tick();
      tick();
      load_pulse(o_r, d_r);
      tx_en = 1'b0;
      tick();
      tick();
      data_lane0 = d2;
      tx_en = 1'b1;
      tick();
      checks++;
      if ({enable_ser, busy} !== 2'b11 || lane_0_word !== d0) begin
         errors++;
         $display("FAIL drain_resume got %b %h exp 11 %h", {enable_ser, busy}, lane_0_word, d0);
      end
      gap(2);
      load_pulse(o_r, d_r);
      checks++;
      if ({o_r, d_r, slot_src} !== 4'b0110 || lane_0_word !== d2) begin
         errors++;
         $display("FAIL drain_no_drop got %b %h exp 0110 %h", {o_r, d_r, slot_src}, lane_0_word, d2);
      end
   endtask

   task automatic test_reset_mid_run();
      logic o_r, d_r;
      do_reset();
      gen_speed_in = 2'b10;
      os_valid     = 1'b1;
      os_word      = pat_os;
      tx_en        = 1'b1;
      tick();
      tick();
      load_pulse(o_r, d_r);
      gap(3);
      rst      = 1'b1;
      ser_load = 1'b1;
      #1;
      checks++;
      if ({os_ready, data_ready} !== 2'b00) begin
         errors++;
         $display("FAIL rst_cycle_ready got %b exp 00", {os_ready, data_ready});
      end
      tick();
      rst      = 1'b0;
      ser_load = 1'b0;
      checks++;
      if ({enable_ser, busy, slot_src, gen_speed} !== 6'b0 || lane_0_word !== '0 || lane_1_word !== '0) begin
         errors++;
         $display("FAIL rst_mid_run got %b %h %h exp 0", {enable_ser, busy, slot_src, gen_speed}, lane_0_word, lane_1_word);
      end
   endtask

   initial begin
      rst          = 1'b1;
      tx_en        = 1'b0;
      gen_speed_in = 2'b00;
      ser_load     = 1'b0;
      os_valid     = 1'b0;
      data_valid   = 1'b0;
      os_word      = '0;
      data_lane0   = '0;
      data_lane1   = '0;
      pat_a5       = {4'h5, {16{8'hA5}}};
      pat_os       = {4'h3, {16{8'h3C}}};
      d0           = {4'h1, {16{8'h12}}};
      d1           = {4'h9, {16{8'h96}}};
      d2           = {4'hE, {16{8'hE7}}};
      ones         = '1;

      test_reset();
      test_gen3_startup();
      test_fairness();
      test_idle_fill();
      test_masking();
      test_drain();
      test_reset_mid_run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
